jtdd_colmix: RTL and testbench

//   Colour mixer directly downstream of the character layer. Merges char_pxl,
//   the scroll-layer pixel and the object pixel by fixed priority, then looks
//   the winner up in CPU-writable palette RAM (RG byte + B byte). Emits 4-bit
//   RGB with blanking delayed to match the pipeline.

---
 rtl/jtdd_colmix.sv | 117 +++++++++++
 tb/tb_jtdd_colmix.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_colmix.sv
// jtdd_colmix: char > obj > scroll priority mux feeding palette RAM lookup; pixel-to-RGB latency is 2 pxl_cen.
// pal_cs takes the RAM from video (RGB holds, blanks keep shifting); JTDD_COLMIX_DEBUG_EN adds gfx_en layer masks.
module jtdd_colmix #(
    parameter int BLANK_DLY  = 2,
    parameter     SIMFILE_RG = "pal_rg.bin",
    parameter     SIMFILE_B  = "pal_b.bin"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       cen_E,
    input  logic [9:0] cpu_AB,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
`ifdef JTDD_COLMIX_DEBUG_EN
    input  logic [2:0] gfx_en,
`endif
    input  logic [6:0] char_pxl,
    input  logic [6:0] obj_pxl,
    input  logic [6:0] scr_pxl,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    logic [2:0]           layer_en;
    logic                 char_op, obj_op;
    logic [8:0]           pal_idx_d, pal_idx_q;
    logic [8:0]           ram_addr;
    logic                 pal_we, video_adv, blank_ok;
    logic [7:0]           rg_ram [0:511];
    logic [7:0]           b_ram  [0:511];
    logic [7:0]           rg_rd_q, b_rd_q;
    logic                 sel_b_q;
    logic [BLANK_DLY-1:0] hbl_sr_d, hbl_sr_q, vbl_sr_d, vbl_sr_q;
    logic [11:0]          rgb_d, rgb_q;

`ifdef JTDD_COLMIX_DEBUG_EN
    assign layer_en = gfx_en;
`else
    assign layer_en = 3'b111;
`endif

    assign char_op = layer_en[0] && (char_pxl[3:0] != 4'h0);
    assign obj_op  = layer_en[1] && (obj_pxl[3:0]  != 4'h0);

    always_comb begin
        pal_idx_d = 9'h100;
        if (char_op)
            pal_idx_d = {2'b00, char_pxl};
        else if (obj_op)
            pal_idx_d = {2'b01, obj_pxl};
        else if (layer_en[2])
            pal_idx_d = {2'b10, scr_pxl};
    end

    assign video_adv = pxl_cen & ~pal_cs;
    assign pal_we    = pal_cs & ~cpu_wrn & cen_E;
    assign ram_addr  = pal_cs ? cpu_AB[8:0] : pal_idx_q;

    // RAM has no reset: palette contents survive a mid-frame reset
    always_ff @(posedge clk) begin
        if (pal_we && !cpu_AB[9])
            rg_ram[cpu_AB[8:0]] <= cpu_dout;
        if (pal_we && cpu_AB[9])
            b_ram[cpu_AB[8:0]] <= cpu_dout;
        rg_rd_q <= rg_ram[ram_addr];
        b_rd_q  <= b_ram[ram_addr];
        sel_b_q <= cpu_AB[9];
    end

    assign pal_dout = sel_b_q ? b_rd_q : rg_rd_q;

    always_comb begin
        hbl_sr_d = hbl_sr_q;
        vbl_sr_d = vbl_sr_q;
        if (pxl_cen) begin
            hbl_sr_d = BLANK_DLY'({hbl_sr_q, LHBL});
            vbl_sr_d = BLANK_DLY'({vbl_sr_q, LVBL});
        end
    end

    // Blank test uses the delayed value being loaded alongside this RGB sample
    assign blank_ok = hbl_sr_d[BLANK_DLY-1] & vbl_sr_d[BLANK_DLY-1];

    always_comb begin
        rgb_d = rgb_q;
        if (video_adv)
            rgb_d = blank_ok ? {rg_rd_q, b_rd_q[3:0]} : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pal_idx_q <= 9'h000;
            hbl_sr_q  <= '0;
            vbl_sr_q  <= '0;
            rgb_q     <= 12'h000;
        end else begin
            if (video_adv)
                pal_idx_q <= pal_idx_d;
            hbl_sr_q <= hbl_sr_d;
            vbl_sr_q <= vbl_sr_d;
            rgb_q    <= rgb_d;
        end
    end

    assign LHBL_dly = hbl_sr_q[BLANK_DLY-1];
    assign LVBL_dly = vbl_sr_q[BLANK_DLY-1];
    assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_jtdd_colmix.sv
// Bench for jtdd_colmix: vector table, CPU palette access, hold/reset sequences and random pixels vs. a palette model.
module tb_jtdd_colmix;

    logic       clk = 1'b0;
    logic       rst, pxl_cen, cen_E, pal_cs, cpu_wrn;
    logic [9:0] cpu_AB;
    logic [7:0] cpu_dout, pal_dout;
    logic [6:0] char_pxl, obj_pxl, scr_pxl;
    logic       LHBL, LVBL, LHBL_dly, LVBL_dly;
    logic [3:0] red, green, blue;
    logic [2:0] en_m = 3'b111;
`ifdef JTDD_COLMIX_DEBUG_EN
    logic [2:0] gfx_en;
    assign gfx_en = en_m;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rg_m [512];
    logic [7:0] b_m  [512];
    logic [8:0] prev_idx;
    logic       prev_lh, prev_lv;

    typedef struct {
        logic [6:0] c, o, s;
        logic       lh, lv;
        logic [8:0] idx;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    jtdd_colmix dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cen_E(cen_E),
        .cpu_AB(cpu_AB), .pal_cs(pal_cs), .cpu_wrn(cpu_wrn),
        .cpu_dout(cpu_dout), .pal_dout(pal_dout),
`ifdef JTDD_COLMIX_DEBUG_EN
        .gfx_en(gfx_en),
`endif
        .char_pxl(char_pxl), .obj_pxl(obj_pxl), .scr_pxl(scr_pxl),
        .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
        .red(red), .green(green), .blue(blue)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference rules: opaque char wins, then opaque obj, then scroll (or 0x100 if masked)
    function automatic logic [8:0] ref_idx(input logic [6:0] c, o, s, input logic [2:0] en);
        if (en[0] && c[3:0] != 4'h0) return {2'b00, c};
        if (en[1] && o[3:0] != 4'h0) return {2'b01, o};
        if (en[2])                   return {2'b10, s};
        return 9'h100;
    endfunction

    // The sample taken one pixel earlier is what shows on the outputs now
    task automatic check_video(input string tag);
        logic [11:0] exp_rgb;
        exp_rgb = (prev_lh && prev_lv) ? {rg_m[prev_idx], b_m[prev_idx][3:0]} : 12'h000;
        check({tag, " rgb"}, {20'h0, red, green, blue}, {20'h0, exp_rgb});
        check({tag, " blank_dly"}, {30'h0, LHBL_dly, LVBL_dly}, {30'h0, prev_lh, prev_lv});
    endtask

    task automatic step(input logic [6:0] c, o, s, input logic lh, lv,
                        input logic [8:0] idx, input string tag);
        char_pxl = c; obj_pxl = o; scr_pxl = s; LHBL = lh; LVBL = lv;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick(); tick(); tick();
        check_video(tag);
        prev_idx = idx; prev_lh = lh; prev_lv = lv;
    endtask

    initial begin
        logic [6:0] rc, ro, rs;
        logic       rlh, rlv;

        rst = 1'b1; pxl_cen = 1'b0; cen_E = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1;
        cpu_AB = 10'h0; cpu_dout = 8'h0;
        char_pxl = 7'h05; obj_pxl = 7'h0; scr_pxl = 7'h0; LHBL = 1'b1; LVBL = 1'b1;

        // Reset held 3 clk, one pxl_cen inside it
        tick();
        pxl_cen = 1'b1; tick(); pxl_cen = 1'b0;
        tick();
        check("reset rgb", {20'h0, red, green, blue}, 32'h0);
        check("reset blank_dly", {30'h0, LHBL_dly, LVBL_dly}, 32'h0);
        rst = 1'b0;
        prev_idx = 9'h0; prev_lh = 1'b0; prev_lv = 1'b0;
        for (int i = 0; i < 3; i++)
            step(7'h05, 7'h0, 7'h0, 1'b0, 1'b1, 9'h005, "blank after reset");

        // Palette load through the CPU port
        for (int i = 0; i < 512; i++) begin
            rg_m[i] = 8'($urandom);
            b_m[i]  = 8'($urandom);
        end
        rg_m[5] = 8'hA5;
        b_m[5]  = 8'h0C;
        pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            cpu_AB   = 10'(a);
            cpu_dout = (a < 512) ? rg_m[a] : b_m[a - 512];
            tick();
        end
        // Write strobe without cen_E must be ignored
        cen_E = 1'b0; cpu_AB = 10'h005; cpu_dout = 8'hFF;
        tick();
        cen_E = 1'b1; cpu_wrn = 1'b1;
        cpu_AB = 10'h005; tick(); check("read RG[005]", {24'h0, pal_dout}, 32'hA5);
        cpu_AB = 10'h205; tick(); check("read B[005]",  {24'h0, pal_dout}, 32'h0C);
        cpu_AB = 10'h1FF; tick(); check("read RG[1FF]", {24'h0, pal_dout}, {24'h0, rg_m[511]});
        cpu_AB = 10'h3FF; tick(); check("read B[1FF]",  {24'h0, pal_dout}, {24'h0, b_m[511]});
        for (int i = 0; i < 6; i++) begin
            cpu_AB = 10'($urandom);
            tick();
            check("read random", {24'h0, pal_dout},
                  {24'h0, cpu_AB[9] ? b_m[cpu_AB[8:0]] : rg_m[cpu_AB[8:0]]});
        end
        pal_cs = 1'b0;
        tick();

        // Fixed vectors: priority, transparency, single-pixel blanks
        tbl[0]  = '{7'h05, 7'h00, 7'h00, 1'b1, 1'b1, 9'h005};
        tbl[1]  = '{7'h05, 7'h00, 7'h00, 1'b1, 1'b1, 9'h005};
        tbl[2]  = '{7'h10, 7'h23, 7'h11, 1'b1, 1'b1, 9'h0A3};
        tbl[3]  = '{7'h10, 7'h20, 7'h11, 1'b1, 1'b1, 9'h111};
        tbl[4]  = '{7'h7F, 7'h23, 7'h11, 1'b1, 1'b1, 9'h07F};
        tbl[5]  = '{7'h00, 7'h00, 7'h00, 1'b1, 1'b1, 9'h100};
        tbl[6]  = '{7'h05, 7'h00, 7'h00, 1'b0, 1'b1, 9'h005};
        tbl[7]  = '{7'h05, 7'h00, 7'h00, 1'b1, 1'b1, 9'h005};
        tbl[8]  = '{7'h05, 7'h00, 7'h00, 1'b1, 1'b0, 9'h005};
        tbl[9]  = '{7'h20, 7'h45, 7'h03, 1'b1, 1'b1, 9'h0C5};
        tbl[10] = '{7'h20, 7'h45, 7'h03, 1'b1, 1'b1, 9'h0C5};
        tbl[11] = '{7'h2A, 7'h00, 7'h00, 1'b1, 1'b1, 9'h02A};
        tbl[12] = '{7'h2A, 7'h00, 7'h00, 1'b1, 1'b1, 9'h02A};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].c, tbl[i].o, tbl[i].s, tbl[i].lh, tbl[i].lv, tbl[i].idx, "table");
            if (i == 2)
                check("char 05 colour", {20'h0, red, green, blue}, 32'hA5C);
        end

        // pal_cs during active video: RGB holds, blanks still shift, CPU reads
        char_pxl = 7'h33; LHBL = 1'b0; LVBL = 1'b1;
        pal_cs = 1'b1; cpu_wrn = 1'b1; cpu_AB = 10'h005; pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        check("cs pal_dout RG", {24'h0, pal_dout}, 32'hA5);
        check("cs rgb hold", {20'h0, red, green, blue}, {20'h0, rg_m[9'h02A], b_m[9'h02A][3:0]});
        check("cs blank_dly", {30'h0, LHBL_dly, LVBL_dly}, 32'h3);
        cpu_AB = 10'h205;
        tick();
        check("cs pal_dout B", {24'h0, pal_dout}, 32'h0C);
        pal_cs = 1'b0;
        tick(); tick();
        prev_lh = 1'b0; prev_lv = 1'b1;
        step(7'h05, 7'h00, 7'h00, 1'b1, 1'b1, 9'h005, "after cs");
        step(7'h05, 7'h00, 7'h00, 1'b1, 1'b1, 9'h005, "after cs 2");

        // Mid-frame reset: black until two pxl_cen after release
        rst = 1'b1;
        tick();
        check("midframe rst rgb", {20'h0, red, green, blue}, 32'h0);
        check("midframe rst blank", {30'h0, LHBL_dly, LVBL_dly}, 32'h0);
        rst = 1'b0;
        prev_idx = 9'h0; prev_lh = 1'b0; prev_lv = 1'b0;
        step(7'h05, 7'h00, 7'h00, 1'b1, 1'b1, 9'h005, "post rst 1");
        step(7'h05, 7'h00, 7'h00, 1'b1, 1'b1, 9'h005, "post rst 2");
        check("post rst colour", {20'h0, red, green, blue}, 32'hA5C);

`ifdef JTDD_COLMIX_DEBUG_EN
        en_m = 3'b110;
        step(7'h05, 7'h21, 7'h07, 1'b1, 1'b1, 9'h0A1, "dbg char off");
        en_m = 3'b011;
        step(7'h00, 7'h00, 7'h07, 1'b1, 1'b1, 9'h100, "dbg scr off");
        en_m = 3'b000;
        step(7'h05, 7'h21, 7'h07, 1'b1, 1'b1, 9'h100, "dbg all off");
        en_m = 3'b111;
        step(7'h05, 7'h21, 7'h07, 1'b1, 1'b1, 9'h005, "dbg flush");
`endif

        // Random pixels and blanks against the palette model
        for (int i = 0; i < 300; i++) begin
            rc  = {3'($urandom), ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom)};
            ro  = {3'($urandom), ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom)};
            rs  = 7'($urandom);
            rlh = ($urandom_range(4) != 0);
            rlv = ($urandom_range(4) != 0);
`ifdef JTDD_COLMIX_DEBUG_EN
            en_m = 3'($urandom);
`endif
            step(rc, ro, rs, rlh, rlv, ref_idx(rc, ro, rs, en_m), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
